// File: rtl/spi_omega_pkg.sv
// spi_omega_pkg: shared omega-link width, timing defaults and transmitter state encoding
package spi_omega_pkg;
  localparam int OMEGA_W = 40;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_GAP_CYCLES = 8;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: SCK half-period counter; phase_end marks the last cycle of each phase
module spi_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic phase_end
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_cnt;
  assign phase_end = div_cnt == DW'(CLK_DIV - 1);
  always_ff @(posedge clk)
    div_cnt <= (rst || clr || phase_end) ? '0 : div_cnt + DW'(1);
endmodule

// File: rtl/spi_omega_tx.sv
// spi_omega_tx: SPI mode-0 master, one WORD_W-bit word per handshake MSB first; SPI_TX_MISO_CAPTURE_EN adds MISO capture into rx_data
module spi_omega_tx
  import spi_omega_pkg::*;
#(
  parameter int WORD_W = OMEGA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              CLK67MHZ,
  input  logic              resetPort,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              sckPort,
  output logic              mosiPort,
`ifdef SPI_TX_MISO_CAPTURE_EN
  input  logic              misoPort,
  output logic [WORD_W-1:0] rx_data,
`endif
  output logic              sselPort
);
  localparam int BW = $clog2(WORD_W);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state;
  logic [WORD_W-1:0] shift_reg;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic phase_end;
  // The divider only runs inside a frame, so every frame starts on a fresh phase
  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk(CLK67MHZ),
    .rst(resetPort),
    .clr(state == IDLE || state == GAP),
    .phase_end(phase_end)
  );
  always_ff @(posedge CLK67MHZ) begin
    tx_done <= 1'b0;
    if (resetPort) begin
      state <= IDLE;
      sckPort <= 1'b0;
      sselPort <= 1'b1;
      mosiPort <= 1'b0;
      tx_ready <= 1'b0;
      shift_reg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (tx_ready && tx_valid) begin
            shift_reg <= tx_data;
            sselPort <= 1'b0;
            mosiPort <= tx_data[WORD_W-1];
            tx_ready <= 1'b0;
            bit_cnt <= '0;
            state <= SETUP;
          end else tx_ready <= 1'b1;
        SETUP, LOW:
          if (phase_end) begin
            sckPort <= 1'b1;
            state <= HIGH;
          end
        HIGH:
          if (phase_end) begin
            sckPort <= 1'b0;
            if (bit_cnt == BW'(WORD_W - 1)) state <= HOLD;
            else begin
              shift_reg <= shift_reg << 1;
              mosiPort <= shift_reg[WORD_W-2];
              bit_cnt <= bit_cnt + BW'(1);
              state <= LOW;
            end
          end
        HOLD:
          if (phase_end) begin
            sselPort <= 1'b1;
            tx_done <= 1'b1;
            gap_cnt <= '0;
            state <= GAP;
          end
        GAP:
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            tx_ready <= 1'b1;
            state <= IDLE;
          end else gap_cnt <= gap_cnt + GW'(1);
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPI_TX_MISO_CAPTURE_EN
  logic [WORD_W-1:0] rx_shift;
  // Sample on the same edge that raises sck, i.e. the slave's rising edge
  always_ff @(posedge CLK67MHZ) begin
    if (resetPort) begin
      rx_shift <= '0;
      rx_data <= '0;
    end else begin
      if ((state == SETUP || state == LOW) && phase_end) rx_shift <= {rx_shift[WORD_W-2:0], misoPort};
      if (state == HOLD && phase_end) rx_data <= rx_shift;
    end
  end
`endif
endmodule

// File: tb/tb_spi_omega_tx.sv
// tb_spi_omega_tx: scoreboard bench with an SPI slave monitor on a default and a small (8-bit, div 2) instance
module tb_spi_omega_tx;
  import spi_omega_pkg::*;
  localparam int W[2] = '{OMEGA_W, 8};
  localparam int C[2] = '{DEF_CLK_DIV, 2};
  localparam int G = DEF_GAP_CYCLES;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [39:0] data0 = '0;
  logic [7:0] data1 = '0;
  logic valid0 = 1'b0, valid1 = 1'b0;
  logic ready0, ready1, done0, done1, sck0, sck1, mosi0, mosi1, ssel0, ssel1;
`ifdef SPI_TX_MISO_CAPTURE_EN
  logic miso0 = 1'b0, miso1 = 1'b0;
  logic [39:0] rxd0;
  logic [7:0] rxd1;
  logic [39:0] miso_pat = 40'hDE_ADBE_EF01;
  int midx = -1;
`endif
  spi_omega_tx dut0 (
    .CLK67MHZ(clk), .resetPort(rst), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .tx_done(done0), .sckPort(sck0), .mosiPort(mosi0),
`ifdef SPI_TX_MISO_CAPTURE_EN
    .misoPort(miso0), .rx_data(rxd0),
`endif
    .sselPort(ssel0)
  );
  spi_omega_tx #(.WORD_W(8), .CLK_DIV(2)) dut1 (
    .CLK67MHZ(clk), .resetPort(rst), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx_done(done1), .sckPort(sck1), .mosiPort(mosi1),
`ifdef SPI_TX_MISO_CAPTURE_EN
    .misoPort(miso1), .rx_data(rxd1),
`endif
    .sselPort(ssel1)
  );
  int pass_cnt = 0, total = 0, cyc = 0;
  logic [39:0] q0[$], q1[$];
  int rises[2] = '{0, 0}, low_cnt[2] = '{0, 0}, high_cnt[2] = '{0, 0}, frames[2] = '{0, 0};
  int since_chg[2] = '{1000, 1000}, since_rise[2] = '{1000, 1000};
  logic psck[2] = '{1'b0, 1'b0}, pssel[2] = '{1'b1, 1'b1}, pmosi[2] = '{1'b0, 1'b0};
  logic aborted[2] = '{1'b0, 1'b0};
  logic [63:0] rx[2] = '{64'd0, 64'd0};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  // Bench-side SPI slave: frame timing, MOSI stability and scoreboard compare
  task automatic mon(input int i, input logic s, input logic m, input logic ss, input logic d, input logic rdy);
    logic rise_ss = ss && !pssel[i];
    logic fall_ss = !ss && pssel[i];
    logic [39:0] exp = '0;
    since_chg[i]++;
    since_rise[i]++;
    if (fall_ss) begin
      check("sck_at_ssel_fall", s, 0);
      if (!aborted[i] && frames[i] > 0) check("gap_min", high_cnt[i] >= G, 1);
      aborted[i] = 1'b0;
      low_cnt[i] = 0;
      rises[i] = 0;
      rx[i] = '0;
    end
    if (!ss) begin
      low_cnt[i]++;
      check("ready_in_frame", rdy, 0);
      if (m !== pmosi[i]) begin
        if (!fall_ss) check("mosi_after_rise", since_rise[i] >= C[i], 1);
        since_chg[i] = 0;
      end
      if (s && !psck[i]) begin
        check("mosi_before_rise", since_chg[i] >= C[i], 1);
        rx[i] = {rx[i][62:0], m};
        rises[i]++;
        since_rise[i] = 0;
      end
    end else high_cnt[i]++;
    if (d || rise_ss) check("done_pulse", d, rise_ss && !rst);
    if (rise_ss) begin
      check("sck_at_ssel_rise", s, 0);
      if ((i ? q1.size() : q0.size()) == 0) check("unexpected_frame", 1, 0);
      else if (i) exp = q1.pop_front();
      else exp = q0.pop_front();
      if (!rst) begin
        check("rx_word", rx[i], exp);
        check("sck_rises", rises[i], W[i]);
        check("ssel_low", low_cnt[i], (2 * W[i] + 1) * C[i]);
        frames[i]++;
      end
      aborted[i] = rst;
      high_cnt[i] = 0;
    end
    psck[i] = s;
    pssel[i] = ss;
    pmosi[i] = m;
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
`ifdef SPI_TX_MISO_CAPTURE_EN
    if (!ssel0 && pssel[0]) begin
      miso0 = miso_pat[39];
      midx = 38;
    end else if (!ssel0 && !sck0 && psck[0] && midx >= 0) begin
      miso0 = miso_pat[midx];
      midx--;
    end
    if (done0) check("rx_data0", rxd0, miso_pat);
    if (done1) check("rx_data1", rxd1, 0);
`endif
    mon(0, sck0, mosi0, ssel0, done0, ready0);
    mon(1, sck1, mosi1, ssel1, done1, ready1);
  end
  task automatic send(input int i, input logic [39:0] w, output int t);
    int n = 0;
    if (i) begin data1 = w[7:0]; valid1 = 1'b1; end
    else begin data0 = w; valid0 = 1'b1; end
    while (!(i ? ready1 : ready0) && n < 5000) begin @(negedge clk); n++; end
    check("accept_timeout", n < 5000, 1);
    t = cyc;
    if (i) q1.push_back(w);
    else q0.push_back(w);
    @(negedge clk);
  endtask
  task automatic wait_idle(input int i);
    int n = 0;
    while (((i ? q1.size() : q0.size()) != 0 || !(i ? ready1 : ready0)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 5000, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t1, t2;
    repeat (5) begin
      @(negedge clk);
      check("rst_ssel", ssel0, 1);
      check("rst_sck", sck0, 0);
      check("rst_ready", ready0, 0);
      check("rst_ready1", ready1, 0);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    check("ready_after_rst", ready0, 1);
    check("ready1_after_rst", ready1, 1);
    @(negedge clk);
    send(0, 40'hA5_0F0F_3C96, t1);
    valid0 = 1'b0;
    wait_idle(0);
    send(0, 40'h00_0000_0001, t1);
    send(0, 40'hFF_FFFF_FFFF, t2);
    valid0 = 1'b0;
    check("b2b_period", t2 - t1, (2 * W[0] + 1) * C[0] + G + 1);
    wait_idle(0);
    send(0, 40'h5A_C3C3_A55A, t1);
    valid0 = 1'b0;
    for (int n = 0; rises[0] < 18 && n < 5000; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("abort_ssel", ssel0, 1);
    check("abort_sck", sck0, 0);
    check("abort_done", done0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    check("ready_after_abort", ready0, 1);
    @(negedge clk);
    send(0, 40'h12_3456_789A, t1);
    valid0 = 1'b0;
    wait_idle(0);
    send(1, 40'h81, t1);
    valid1 = 1'b0;
    wait_idle(1);
    send(1, 40'h3C, t1);
    valid1 = 1'b0;
    wait_idle(1);
    check("frames0", frames[0], 4);
    check("frames1", frames[1], 2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
